// File: rtl/btb_update_ctrl.sv
// Write-port controller for the 2-way BTB: queues EX-stage resolve updates, picks the hit/forwarded/LRU way,
// and sequences a full-table invalidate walk that stalls IF lookups until it completes.
module btb_update_ctrl #(
    parameter int SETS  = 8,
    parameter int TAG_W = 27,
    parameter int TGT_W = 32,
    localparam int INDEX_W = $clog2(SETS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic [TGT_W-1:0]   upd_target,
    input  logic               upd_hit1,
    input  logic               upd_hit2,
    input  logic               lru_write_bit,
    output logic               lru_update,
    output logic [INDEX_W-1:0] lru_update_index,
    output logic               lru_update_branch1,
    output logic               lru_update_branch2,
    output logic               btb_we1,
    output logic               btb_we2,
    output logic [INDEX_W-1:0] btb_windex,
    output logic [TAG_W-1:0]   btb_wtag,
    output logic [TGT_W-1:0]   btb_wtarget,
    output logic               btb_wvalid,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done,
    output logic               lookup_stall
);

    typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

    state_t state, state_next;

    logic [INDEX_W-1:0] q_index  [2];
    logic [TAG_W-1:0]   q_tag    [2];
    logic [TGT_W-1:0]   q_target [2];
    logic               q_hit1   [2];
    logic               q_hit2   [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;

    logic               fwd_valid;
    logic [INDEX_W-1:0] fwd_index;
    logic [TAG_W-1:0]   fwd_tag;
    logic               fwd_way2;

    logic [INDEX_W-1:0] idx;

    logic [INDEX_W-1:0] head_index;
    logic [TAG_W-1:0]   head_tag;
    logic [TGT_W-1:0]   head_target;
    logic               head_hit1;
    logic               head_hit2;
    logic               push;
    logic               issue;
    logic               flush_start;
    logic               fwd_match;
    logic               sel_way2;
    logic               known_way;

    assign head_index  = q_index[rd_ptr];
    assign head_tag    = q_tag[rd_ptr];
    assign head_target = q_target[rd_ptr];
    assign head_hit1   = q_hit1[rd_ptr];
    assign head_hit2   = q_hit2[rd_ptr];

    assign flush_start = (state == IDLE) && flush_req;
    assign upd_ready   = (state == IDLE) && !flush_req && (count < 2'd2);
    assign push        = upd_valid && upd_ready;
    assign issue       = (state == IDLE) && !flush_req && (count != 2'd0);

    // A miss that repeats the previous cycle's issue reuses its way so the branch is not inserted twice.
    assign fwd_match = fwd_valid && !head_hit1 && !head_hit2
                       && (fwd_index == head_index) && (fwd_tag == head_tag);
    assign sel_way2  = head_hit1 ? 1'b0 :
                       head_hit2 ? 1'b1 :
                       fwd_match ? fwd_way2 : lru_write_bit;
    assign known_way = head_hit1 || head_hit2 || fwd_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_req) state_next = FLUSH;
            FLUSH:   if (idx == INDEX_W'(SETS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lru_update         = 1'b0;
        lru_update_index   = '0;
        lru_update_branch1 = 1'b0;
        lru_update_branch2 = 1'b0;
        btb_we1            = 1'b0;
        btb_we2            = 1'b0;
        btb_windex         = '0;
        btb_wtag           = '0;
        btb_wtarget        = '0;
        btb_wvalid         = 1'b0;
        flush_busy         = (state != IDLE);
        lookup_stall       = (state != IDLE);
        flush_done         = (state == DONE);
        case (state)
            IDLE: begin
                lru_update_index = head_index;
                if (issue) begin
                    btb_we1            = !sel_way2;
                    btb_we2            = sel_way2;
                    btb_windex         = head_index;
                    btb_wtag           = head_tag;
                    btb_wtarget        = head_target;
                    btb_wvalid         = 1'b1;
                    lru_update         = 1'b1;
                    lru_update_branch1 = known_way && !sel_way2;
                    lru_update_branch2 = known_way && sel_way2;
                end
            end
            FLUSH: begin
                btb_we1    = 1'b1;
                btb_we2    = 1'b1;
                btb_windex = idx;
            end
            default: ;
        endcase
    end

    // Two-entry FIFO; a flush start discards whatever is still queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                q_index[i]  <= '0;
                q_tag[i]    <= '0;
                q_target[i] <= '0;
                q_hit1[i]   <= 1'b0;
                q_hit2[i]   <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush_start) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_index[wr_ptr]  <= upd_index;
                q_tag[wr_ptr]    <= upd_tag;
                q_target[wr_ptr] <= upd_target;
                q_hit1[wr_ptr]   <= upd_hit1;
                q_hit2[wr_ptr]   <= upd_hit2;
                wr_ptr           <= ~wr_ptr;
            end
            if (issue) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, issue};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_index <= '0;
            fwd_tag   <= '0;
            fwd_way2  <= 1'b0;
        end else if (flush_start) begin
            fwd_valid <= 1'b0;
        end else begin
            fwd_valid <= issue;
            if (issue) begin
                fwd_index <= head_index;
                fwd_tag   <= head_tag;
                fwd_way2  <= sel_way2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (state == FLUSH) begin
            idx <= (idx == INDEX_W'(SETS - 1)) ? '0 : idx + INDEX_W'(1);
        end else begin
            idx <= '0;
        end
    end

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Write-port controller for the 2-way, 8-set branch target buffer. It accepts EX-stage resolve updates through a 2-entry queue and selects the victim or hit way using the LRU bit. It drives the BTB array write port and the LRU table's update interface. It also sequences a full-table invalidate (flush) that walks every set and stalls IF-stage lookups until the walk completes.

## Interface
- SETS, 8, number of BTB sets; INDEX_W = log2(SETS)
- TAG_W, 27, BTB tag width
- TGT_W, 32, branch target width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- upd_valid  in  1  EX update request
- upd_ready  out  1  queue can accept an update
- upd_index  in  INDEX_W  set index of the update
- upd_tag  in  TAG_W  tag of the update
- upd_target  in  TGT_W  resolved target
- upd_hit1 / upd_hit2  in  1  update matched way 1 / way 2 at lookup (at most one is set)
- lru_write_bit  in  1  LRU bit of lru_update_index, returned combinationally by the LRU table
- lru_update  out  1  LRU update strobe
- lru_update_index  out  INDEX_W  set presented to LRU
- lru_update_branch1 / lru_update_branch2  out  1  the write targets an existing way 1 / way 2
- btb_we1 / btb_we2  out  1  BTB way write enables
- btb_windex  out  INDEX_W  write set
- btb_wtag  out  TAG_W  write tag
- btb_wtarget  out  TGT_W  write target
- btb_wvalid  out  1  valid bit written
- flush_req  in  1  single-cycle flush request
- flush_busy  out  1  flush in progress
- flush_done  out  1  one-cycle pulse when the flush completes
- lookup_stall  out  1  IF must not look up the BTB or drive branch1_used/branch2_used

## Operation
- Queue: 2-entry FIFO holding {index, tag, target, hit1, hit2}.
  - upd_ready = (state==IDLE) && !flush_req && (count<2).
  - Enqueue on upd_valid && upd_ready.
  - There is no same-cycle pass-through: an entry is issued at the earliest one cycle after it is enqueued.
- Issue, in IDLE with the queue non-empty and no flush_req: pop the head and perform the write in the same cycle.
  - lru_update_index = head.index in IDLE, including cycles with no issue.
  - Way selection:
    - hit1 selects way 1.
    - else hit2 selects way 2.
    - else a forward match selects the forwarded way (see below).
    - else lru_write_bit==0 selects way 1; lru_write_bit==1 selects way 2.
  - Outputs driven for the issue:
    - btb_we of the chosen way = 1; btb_wvalid = 1.
    - btb_windex/wtag/wtarget = head fields.
    - lru_update = 1.
    - lru_update_branch1/2 = 1 when the chosen way was a hit or a forward match; otherwise both are 0, so the LRU table treats the write as a new insertion.
- Forwarding: the controller registers {index, tag, way} of the previous-cycle issue. If the head is a miss and matches that index and tag, it uses the registered way and treats the write as a hit. This prevents a duplicate entry when back-to-back misses to the same branch are queued.
- States:
  - IDLE: on flush_req, clear the queue and the forward register, then go to FLUSH. Nothing is issued that cycle and any enqueue that cycle is refused.
  - FLUSH: counter idx runs 0..SETS-1, one set per cycle.
    - btb_we1 = btb_we2 = 1, btb_wvalid = 0, btb_windex = idx, tag and target = 0, lru_update = 0.
    - After idx == SETS-1, go to DONE.
  - DONE: flush_done = 1 for one cycle, then go to IDLE.
- flush_busy and lookup_stall = (state != IDLE).
- flush_req outside IDLE is ignored.
- A flush does not change LRU state.

## Timing
- Reset, or rst_n deassertion mid-flush:
  - state = IDLE, queue empty, idx = 0, forward register invalid.
  - All write and strobe outputs = 0.
  - upd_ready = 1 (combinational, given flush_req == 0).
- Write latency: enqueue at cycle N gives the BTB write at N+1 at the earliest. A second queued entry is written at N+2.
- Throughput: one write per cycle. The queue sustains 1 update per cycle, because ready depends on the registered count, which a pop in the same cycle keeps below 2.
- Flush: flush_req accepted at cycle N gives FLUSH writes at N+1..N+SETS and flush_done at N+SETS+1. upd_ready returns at N+SETS+2.
- Full queue: upd_ready = 0. With upd_valid held, the entry is accepted the cycle after a pop.
- Simultaneous flush_req and a non-empty queue: flush wins, and the queued updates are dropped without being written.

## Test plan
- Reset, then one miss update {idx 3, tag 0x5, target 0x100}, lru_write_bit = 0: the next cycle shows btb_we1 = 1, btb_windex = 3, btb_wvalid = 1, lru_update = 1, branch1 = branch2 = 0.
- Hit updates: upd_hit2 = 1 at idx 5 gives btb_we2 = 1 and lru_update_branch2 = 1, independent of lru_write_bit.
- Forwarding: two consecutive misses {idx 2, tag 0x9} with lru_write_bit = 1. The first writes way 2 as a new insertion. The second writes way 2 with branch2 = 1, and no way-1 write occurs.
- Backpressure: upd_valid held for 4 cycles with a stalled issue (flush active) shows ready = 0 and no enqueue. With issue running, the sequence shows ready high every cycle and 4 writes on consecutive cycles.
- Flush: flush_req with 1 queued entry gives 8 cycles with we1 = we2 = 1, wvalid = 0, windex 0..7, then flush_done for 1 cycle. The queued entry is never written and lookup_stall is high for 9 cycles.
- Async reset asserted at flush idx 4: outputs drop to 0 immediately. After release, state is IDLE and upd_ready = 1.
